ir_freq_decoder: RTL and testbench



---
 rtl/ir_pkg.sv | 20 ++
 rtl/ir_sync_edge.sv | 74 +++++++
 rtl/ir_freq_decoder.sv | 156 +++++++++++++++
 tb/tb_ir_freq_decoder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// ----------------------------------------------------------------------------
// ir_pkg
// Shared definitions for the IR beacon decoder and the IR instruction stage.
//   IR_*        : one-hot 4-bit IR instruction codes (IR_NONE = no beacon/code)
//   ir_state_e  : period-measurement FSM states
// ----------------------------------------------------------------------------
package ir_pkg;

  localparam logic [3:0] IR_NONE  = 4'b0000;
  localparam logic [3:0] IR_STOP  = 4'b0001;  // 8 kHz
  localparam logic [3:0] IR_200HZ = 4'b0010;
  localparam logic [3:0] IR_1KHZ  = 4'b0100;
  localparam logic [3:0] IR_5KHZ  = 4'b1000;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } ir_state_e;

endpackage

// File: rtl/ir_sync_edge.sv
// ----------------------------------------------------------------------------
// ir_sync_edge
// Brings the asynchronous IR receiver output into the clk domain and emits a
// one-cycle pulse on each rising edge of the (optionally filtered) level.
// Optional feature macro: IR_GLITCH_FILTER_EN -- when defined, the level must
// be stable for GLITCH_CYC consecutive cycles before the edge detector sees it.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   din   : raw IR input (asynchronous)
//   rise  : one-cycle rising-edge pulse
// ----------------------------------------------------------------------------
module ir_sync_edge
`ifdef IR_GLITCH_FILTER_EN
#(
  parameter int GLITCH_CYC = 16
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic sync_q1;
  logic sync_q2;
  logic lvl;
  logic lvl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
    end
  end

`ifdef IR_GLITCH_FILTER_EN
  localparam int GW = $clog2(GLITCH_CYC + 1);

  logic [GW-1:0] stable_cnt;
  logic          filt;

  // stable_cnt counts consecutive cycles where the synchronized level
  // disagrees with the filtered one; any agreeing cycle restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      filt       <= 1'b0;
    end else if (sync_q2 == filt) begin
      stable_cnt <= '0;
    end else if (stable_cnt == GW'(GLITCH_CYC - 1)) begin
      filt       <= sync_q2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + GW'(1);
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync_q2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_q <= 1'b0;
    else        lvl_q <= lvl;
  end

  assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/ir_freq_decoder.sv
// ----------------------------------------------------------------------------
// ir_freq_decoder
// Measures the period of the demodulated IR beacon and classifies it into the
// one-hot IR instruction code. The code only moves after CONFIRM consecutive
// periods fall in the same class, and is cleared if the beacon disappears for
// TIMEOUT_CYC cycles.
// Optional feature macro: IR_GLITCH_FILTER_EN (adds GLITCH_CYC input filter).
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   ir_in       : raw IR receiver output (asynchronous)
//   ir_code     : one-hot code (0001 8 kHz stop, 0010 200 Hz, 0100 1 kHz,
//                 1000 5 kHz, 0000 none)
//   code_strobe : one-cycle pulse whenever ir_code changes value
//   period      : last measured period in clk cycles
//
// state   | meaning
// IDLE    | no beacon reference edge yet; counter held at 0
// MEASURE | counting cycles since the last rising edge
// ----------------------------------------------------------------------------
module ir_freq_decoder
  import ir_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TOL_PCT     = 10,
  parameter int CONFIRM     = 3,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int CNT_W       = 20
`ifdef IR_GLITCH_FILTER_EN
  ,
  parameter int GLITCH_CYC  = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ir_in,
  output logic [3:0]       ir_code,
  output logic             code_strobe,
  output logic [CNT_W-1:0] period
);

  localparam int N_STOP = CLK_HZ / 8000;
  localparam int N_5K   = CLK_HZ / 5000;
  localparam int N_1K   = CLK_HZ / 1000;
  localparam int N_200  = CLK_HZ / 200;

  localparam logic [CNT_W-1:0] LO_STOP = CNT_W'(N_STOP * (100 - TOL_PCT) / 100);
  localparam logic [CNT_W-1:0] HI_STOP = CNT_W'(N_STOP * (100 + TOL_PCT) / 100);
  localparam logic [CNT_W-1:0] LO_5K   = CNT_W'(N_5K * (100 - TOL_PCT) / 100);
  localparam logic [CNT_W-1:0] HI_5K   = CNT_W'(N_5K * (100 + TOL_PCT) / 100);
  localparam logic [CNT_W-1:0] LO_1K   = CNT_W'(N_1K * (100 - TOL_PCT) / 100);
  localparam logic [CNT_W-1:0] HI_1K   = CNT_W'(N_1K * (100 + TOL_PCT) / 100);
  localparam logic [CNT_W-1:0] LO_200  = CNT_W'(N_200 * (100 - TOL_PCT) / 100);
  localparam logic [CNT_W-1:0] HI_200  = CNT_W'(N_200 * (100 + TOL_PCT) / 100);

  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT_CYC);
  localparam logic [2:0]       CONF3 = 3'(CONFIRM);

  ir_state_e        state;
  logic             rise_pulse;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] meas;
  logic             timeout;
  logic [3:0]       cls;
  logic [3:0]       candidate;
  logic [3:0]       pend_code;
  logic             pend;
  logic [2:0]       match_cnt;
  logic [2:0]       match_nxt;

  ir_sync_edge
`ifdef IR_GLITCH_FILTER_EN
    #(.GLITCH_CYC(GLITCH_CYC))
`endif
  u_sync_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (ir_in),
    .rise (rise_pulse)
  );

  // meas is the period that would be reported if an edge arrived this cycle.
  assign meas    = count + CNT_W'(1);
  assign timeout = (meas == TMO);

  // An edge coinciding with the timeout is treated as an unclassified period.
  always_comb begin
    cls = IR_NONE;
    if (!timeout) begin
      if (meas >= LO_STOP && meas <= HI_STOP)     cls = IR_STOP;
      else if (meas >= LO_5K && meas <= HI_5K)    cls = IR_5KHZ;
      else if (meas >= LO_1K && meas <= HI_1K)    cls = IR_1KHZ;
      else if (meas >= LO_200 && meas <= HI_200)  cls = IR_200HZ;
    end
  end

  always_comb begin
    match_nxt = 3'd1;
    if (cls == candidate) match_nxt = (match_cnt >= CONF3) ? CONF3 : match_cnt + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      period      <= '0;
      candidate   <= IR_NONE;
      match_cnt   <= 3'd0;
      pend        <= 1'b0;
      pend_code   <= IR_NONE;
      ir_code     <= IR_NONE;
      code_strobe <= 1'b0;
    end else begin
      code_strobe <= 1'b0;
      pend        <= 1'b0;

      // Confirmed class lands one cycle after the confirming edge; the class
      // is latched so a quick following edge cannot alter what is committed.
      if (pend) begin
        ir_code     <= pend_code;
        code_strobe <= (pend_code != ir_code);
      end

      case (state)
        IDLE: begin
          count <= '0;
          if (rise_pulse) state <= MEASURE;
        end

        MEASURE: begin
          if (rise_pulse) begin
            period    <= meas;
            count     <= '0;
            candidate <= cls;
            match_cnt <= match_nxt;
            if (match_nxt == CONF3) begin
              pend      <= 1'b1;
              pend_code <= cls;
            end
          end else if (timeout) begin
            ir_code     <= IR_NONE;
            code_strobe <= (ir_code != IR_NONE);
            candidate   <= IR_NONE;
            match_cnt   <= 3'd0;
            count       <= '0;
            state       <= IDLE;
          end else if (count != TMO) begin
            count <= meas;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_freq_decoder.sv
`timescale 1ns/1ps
module tb_ir_freq_decoder;

  localparam int CLK_HZ      = 800_000;
  localparam int TOL_PCT     = 10;
  localparam int CONFIRM     = 3;
  localparam int TIMEOUT_CYC = 5000;
  localparam int CNT_W       = 20;
`ifdef IR_GLITCH_FILTER_EN
  localparam int LAT_X = 16;
`else
  localparam int LAT_X = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ir_in;
  logic [3:0]       ir_code;
  logic             code_strobe;
  logic [CNT_W-1:0] period;

  ir_freq_decoder #(
    .CLK_HZ     (CLK_HZ),
    .TOL_PCT    (TOL_PCT),
    .CONFIRM    (CONFIRM),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ir_in      (ir_in),
    .ir_code    (ir_code),
    .code_strobe(code_strobe),
    .period     (period)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]       code;
    logic [CNT_W-1:0] per;
    int unsigned      t;
    bit               to;
  } exp_t;

  exp_t        sb[$];
  bit          m_active = 1'b0;
  int unsigned m_last   = 0;
  logic [3:0]  m_code   = 4'b0000;
  logic [3:0]  m_run_cls = 4'b0000;
  int          m_run_len = 0;
  int          m_period  = 0;

  function automatic int win_lo(input int f);
    return (CLK_HZ / f) * (100 - TOL_PCT) / 100;
  endfunction

  function automatic int win_hi(input int f);
    return (CLK_HZ / f) * (100 + TOL_PCT) / 100;
  endfunction

  function automatic logic [3:0] classify(input int p);
    if (p >= TIMEOUT_CYC) return 4'b0000;
    if (p >= win_lo(8000) && p <= win_hi(8000)) return 4'b0001;
    if (p >= win_lo(200)  && p <= win_hi(200))  return 4'b0010;
    if (p >= win_lo(1000) && p <= win_hi(1000)) return 4'b0100;
    if (p >= win_lo(5000) && p <= win_hi(5000)) return 4'b1000;
    return 4'b0000;
  endfunction

  // A rise at cycle 'now', followed by 'gap' cycles until the next rise.
  task automatic model_rise(input int unsigned now, input int gap);
    logic [3:0] c;
    int p;
    if (m_active) begin
      p = int'(now - m_last);
      c = classify(p);
      if (m_run_len > 0 && c == m_run_cls) m_run_len++;
      else begin
        m_run_cls = c;
        m_run_len = 1;
      end
      m_period = p;
      if (m_run_len >= CONFIRM && m_run_cls != m_code) begin
        m_code = m_run_cls;
        sb.push_back('{code: c, per: CNT_W'(p), t: now, to: 1'b0});
      end
    end
    m_active = 1'b1;
    m_last   = now;
    if (gap > TIMEOUT_CYC) begin
      if (m_code != 4'b0000) begin
        m_code = 4'b0000;
        sb.push_back('{code: 4'b0000, per: CNT_W'(m_period), t: now, to: 1'b1});
      end
      m_active  = 1'b0;
      m_run_len = 0;
    end
  endtask

  // ---------------- monitor ----------------
  logic [3:0] prev_code = 4'b0000;

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n !== 1'b1) begin
      prev_code = 4'b0000;
    end else begin
      if (ir_code !== prev_code) check("strobe_on_change", 32'(code_strobe), 32'd1);
      if (code_strobe === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: ir_code %b with no change expected (cycle %0d)", ir_code, cyc);
        end else begin
          e = sb.pop_front();
          check(e.to ? "timeout_code" : "confirm_code", 32'(ir_code), 32'(e.code));
          check(e.to ? "timeout_period" : "confirm_period", 32'(period), 32'(e.per));
          if (e.to)
            check_range("timeout_latency", int'(cyc - e.t), TIMEOUT_CYC + LAT_X, TIMEOUT_CYC + LAT_X + 4);
          else
            check_range("confirm_latency", int'(cyc - e.t), 2 + LAT_X, 5 + LAT_X);
        end
      end
      prev_code = ir_code;
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at a negedge exactly h+l cycles later.
  task automatic pulse(input int h, input int l, input bit spike = 1'b0);
    ir_in = 1'b1;
    model_rise(cyc + 1, h + l);
    repeat (h) @(negedge clk);
    check("period", 32'(period), 32'(m_period));
    ir_in = 1'b0;
    if (spike) begin
      repeat (l / 3) @(negedge clk);
      ir_in = 1'b1;
      repeat (5) @(negedge clk);
      ir_in = 1'b0;
      repeat (l - l / 3 - 5) @(negedge clk);
    end else begin
      repeat (l) @(negedge clk);
    end
  endtask

  task automatic pp(input int p);
    int h;
    h = int'($urandom_range(p / 4, 3 * p / 4));
    pulse(h, p - h);
  endtask

  function automatic int pick_period(input int kind);
    int f;
    int r;
    case (kind)
      0:       f = 8000;
      1:       f = 5000;
      2:       f = 1000;
      default: f = 0;
    endcase
    r = int'($urandom_range(0, 3));
    if (f != 0) begin
      if (r == 0) return win_lo(f);
      if (r == 1) return win_hi(f);
      return int'($urandom_range(win_lo(f), win_hi(f)));
    end
    case (r)
      0:       return int'($urandom_range(64, win_lo(8000) - 1));
      1:       return int'($urandom_range(win_hi(8000) + 1, win_lo(5000) - 1));
      2:       return int'($urandom_range(win_hi(5000) + 1, win_lo(1000) - 1));
      default: return int'($urandom_range(win_hi(1000) + 1, 1200));
    endcase
  endfunction

  int seq_c[13] = '{100, 100, 100, 100, 90, 110, 89, 111, 112, 144, 176, 144, 160};

  initial begin
    int kind;
    int len;
    rst_n = 1'b0;
    ir_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ir_code", 32'(ir_code), 32'd0);
    check("reset_strobe", 32'(code_strobe), 32'd0);
    check("reset_period", 32'(period), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 5 kHz lock, then beacon lost
    repeat (4) pulse(80, 80);
    pulse(80, TIMEOUT_CYC + 300);

    // 8 kHz lock, window boundaries, unclassified run, 5 kHz re-lock
    foreach (seq_c[i]) pp(seq_c[i]);

    // 1 kHz lock, switch to 200 Hz, back to 1 kHz, out-of-window run, alternation
    repeat (3) pp(800);
    repeat (3) pp(4000);
    repeat (3) pp(800);
    repeat (3) pp(128);
    repeat (3) begin
      pp(160);
      pp(128);
    end

    // randomized runs
    for (int r = 0; r < 12; r++) begin
      kind = int'($urandom_range(0, 3));
      len  = int'($urandom_range(1, 3));
      for (int k = 0; k < len; k++) pp(pick_period(kind));
    end

`ifdef IR_GLITCH_FILTER_EN
    repeat (6) pulse(80, 80, 1'b1);
`endif

    // asynchronous reset while locked at 5 kHz
    repeat (4) pulse(80, 80);
    ir_in = 1'b1;
    model_rise(cyc + 1, 0);
    repeat (20) @(negedge clk);
    check("pre_reset_code", 32'(ir_code), 32'(m_code));
    check("pre_reset_queue", 32'(sb.size()), 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_code", 32'(ir_code), 32'd0);
    check("async_reset_strobe", 32'(code_strobe), 32'd0);
    check("async_reset_period", 32'(period), 32'd0);
    ir_in     = 1'b0;
    m_active  = 1'b0;
    m_code    = 4'b0000;
    m_run_len = 0;
    m_period  = 0;
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // recovery after reset, then let it time out
    repeat (4) pulse(50, 50);
    pulse(50, TIMEOUT_CYC + 300);

    repeat (10) @(negedge clk);
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
